bus_datapath_seq: RTL and testbench
===================================

BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, bus and register width; NREGS, default 16, general register count (power of 2, at least 2); RAW = log2(NREGS).
REQ-002 One clock; reset is synchronous and active-high; clock port clk, reset port reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  request to execute one operation; sampled only in IDLE.
REQ-006 op  in  4  operation code (see REQ-012).
REQ-007 ra, rb, rc  in  RAW  destination and source register indices.
REQ-008 imm, use_imm  in  WIDTH, 1  immediate operand; when use_imm=1 it replaces Rc as the second operand.
REQ-009 ba_mode  in  1  base-address mode: R0 drives 0 onto the bus when selected as a source.
REQ-010 in_port  in  WIDTH  external input, registered every cycle; out_port  out  WIDTH  output register.
REQ-011 busy, done, err  out  1 each; bus_out  out  WIDTH, current bus value; z_out  out  2*WIDTH, Z register.

Function
REQ-012 op encodings SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 MUL (signed, 2*WIDTH result), 7 IN (in_port->Ra), 8 OUT (Rb->out_port), 9 MFHI (HI->Ra), 10 MFLO (LO->Ra); 11-15 illegal.
REQ-013 FSM states SHALL be IDLE, T_Y, T_Z, T_W, DONE.
- ALU ops 0-6: IDLE->T_Y->T_Z->T_W->DONE->IDLE.
- Transfer ops 7-10: IDLE->T_W->DONE->IDLE.
- Illegal ops: IDLE->DONE with err=1.
REQ-014 T_Y SHALL drive Rb onto the bus and load Y with it.
REQ-015 T_Z SHALL drive Rc (or imm) onto the bus and load Z with alu(Y, bus), zero-extended to 2*WIDTH except MUL.
REQ-016 T_W SHALL behave as follows:
- ALU ops 0-5: drive Z[WIDTH-1:0] onto the bus and write Ra.
- MUL: load HI<=Z[2W-1:W] and LO<=Z[W-1:0]; Ra is not written.
- Transfer ops: drive the source onto the bus and write the destination.
REQ-017 done SHALL be high for exactly the DONE cycle; busy SHALL be high in every state other than IDLE.
REQ-018 Latency from the start-sampling edge to done high SHALL be 4 cycles for ALU ops, 2 for transfer ops, and 1 for illegal ops.
REQ-019 op, ra, rb, rc, imm, use_imm and ba_mode SHALL be captured at start acceptance; input changes while busy SHALL have no effect.
REQ-020 start asserted while busy SHALL be ignored; no queueing.
REQ-021 err SHALL be high only in DONE of an illegal op; an illegal op SHALL perform no register writes.
REQ-022 SHL and SHR shift amount SHALL be the operand's low log2(WIDTH) bits; SHR fills with zero.
REQ-023 ADD and SUB SHALL wrap modulo 2^WIDTH, with no flags.
REQ-024 Source R0 with ba_mode=1 SHALL read as 0; writes to R0 SHALL always occur.
REQ-025 ra equal to rb or rc SHALL read the old value and write the new value at T_W.
REQ-026 In IDLE and DONE, bus_out SHALL be 0; bus_out SHALL carry exactly one source per cycle.

Reset
REQ-027 reset SHALL clear all general registers, Y, Z, HI, LO, out_port and the in_port register to 0, and force the FSM to IDLE.
REQ-028 Outputs SHALL be 0 after reset: busy, done, err, bus_out, z_out and out_port.
REQ-029 reset asserted mid-operation SHALL abort it: done is never raised and no partial write survives.
REQ-030 start high in the same cycle as reset SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the op-code constants, the FSM state enum and the ALU-op/transfer-op classification function.
REQ-032 One sub-module alu_param (WIDTH) SHALL implement ops 0-6 combinationally, producing a 2*WIDTH result.
REQ-033 Registers SHALL be an NREGS x WIDTH array, with no per-register instances.

Verification
REQ-034 The bench SHALL cover at least these scenarios (defaults unless stated):
- R1=5, R2=7; start ADD ra=3 rb=1 rc=2 -> done 4 cycles later; R3=12, err=0.
- R1=0x7FFF_FFFF, imm=2, use_imm=1, SUB ra=4 -> R4=0x7FFF_FFFD; then MUL R1 x R1 -> HI=0x3FFF_FFFF, LO=0x0000_0001, MFLO ra=5 -> R5=1, done 2 cycles after start.
- R0=0x100, ba_mode=1, ADD ra=6 rb=0 imm=4 -> R6=4; same op with ba_mode=0 -> R6=0x104.
- op=12 -> done and err high 1 cycle after start; no register change. start pulsed while busy -> ignored.
- ALU op started, reset asserted in T_Z -> next cycle busy=0, done=0; all registers and out_port 0.
- WIDTH=16, NREGS=8; SHL R1=0x0001 by rc value 0x0013 -> shift 3 -> 0x0008; OUT rb=1 -> out_port=0x0008.

Source files
------------

// File: rtl/bus_datapath_seq_pkg.sv
// Shared op-codes, FSM states and op classification for bus_datapath_seq.
package bus_datapath_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_IN   = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;
  localparam logic [3:0] OP_MFHI = 4'd9;
  localparam logic [3:0] OP_MFLO = 4'd10;

  typedef enum logic [2:0] {IDLE, T_Y, T_Z, T_W, DONE} state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

  function automatic logic is_xfer_op(input logic [3:0] op);
    return (op >= OP_IN) && (op <= OP_MFLO);
  endfunction

endpackage

// File: rtl/bus_datapath_seq_alu.sv
// Combinational ALU for ops 0-6; results are zero-extended except the signed MUL.
module alu_param
  import bus_datapath_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] a_sx, b_sx;

  assign sh   = b[SHW-1:0];
  assign a_sx = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx = {{WIDTH{b[WIDTH-1]}}, b};

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y[WIDTH-1:0] = a + b;
      OP_SUB:  y[WIDTH-1:0] = a - b;
      OP_AND:  y[WIDTH-1:0] = a & b;
      OP_OR:   y[WIDTH-1:0] = a | b;
      OP_SHL:  y[WIDTH-1:0] = a << sh;
      OP_SHR:  y[WIDTH-1:0] = a >> sh;
      // Low 2W bits of the sign-extended product equal the signed WxW product.
      OP_MUL:  y = a_sx * b_sx;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register datapath: ALU ops through Y/Z in T_Y/T_Z/T_W, transfers in T_W.
module bus_datapath_seq
  import bus_datapath_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [RAW-1:0]     ra,
  input  logic [RAW-1:0]     rb,
  input  logic [RAW-1:0]     rc,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  input  logic               ba_mode,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   out_port,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   bus_out,
  output logic [2*WIDTH-1:0] z_out
);

  state_t             state;
  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   y_reg, hi, lo, in_reg;
  logic [2*WIDTH-1:0] z, alu_y;

  logic [3:0]         op_q;
  logic [RAW-1:0]     ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]   imm_q;
  logic               use_imm_q, ba_q;

  logic [WIDTH-1:0]   rb_val, rc_val, bus;

  // Base-address mode turns R0 into a constant-zero source.
  assign rb_val = (ba_q && rb_q == '0) ? '0 : regs[rb_q];
  assign rc_val = (ba_q && rc_q == '0) ? '0 : regs[rc_q];

  always_comb begin
    bus = '0;
    case (state)
      T_Y: bus = rb_val;
      T_Z: bus = use_imm_q ? imm_q : rc_val;
      T_W: begin
        case (op_q)
          OP_IN:   bus = in_reg;
          OP_OUT:  bus = rb_val;
          OP_MFHI: bus = hi;
          OP_MFLO: bus = lo;
          default: bus = z[WIDTH-1:0];
        endcase
      end
      default: bus = '0;
    endcase
  end

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (y_reg),
    .b  (bus),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      y_reg     <= '0;
      z         <= '0;
      hi        <= '0;
      lo        <= '0;
      in_reg    <= '0;
      out_port  <= '0;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      ba_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      in_reg <= in_port;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            ra_q      <= ra;
            rb_q      <= rb;
            rc_q      <= rc;
            imm_q     <= imm;
            use_imm_q <= use_imm;
            ba_q      <= ba_mode;
            busy      <= 1'b1;
            if (is_alu_op(op)) begin
              state <= T_Y;
            end else if (is_xfer_op(op)) begin
              state <= T_W;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        T_Y: begin
          y_reg <= bus;
          state <= T_Z;
        end
        T_Z: begin
          z     <= alu_y;
          state <= T_W;
        end
        T_W: begin
          // Only legal ops reach T_W; everything but MUL/OUT writes Ra from the bus.
          if (op_q == OP_MUL) begin
            hi <= z[2*WIDTH-1:WIDTH];
            lo <= z[WIDTH-1:0];
          end else if (op_q == OP_OUT) begin
            out_port <= bus;
          end else begin
            regs[ra_q] <= bus;
          end
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_out = bus;
  assign z_out   = z;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed table, reset-abort sequence, random ops vs reference model, and a 16-bit instance.
module tb_bus_datapath_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, use_imm, ba_mode;
  logic [3:0]  op, ra, rb, rc;
  logic [31:0] imm, in_port, out_port, bus_out;
  logic        busy, done, err;
  logic [63:0] z_out;

  logic        b_reset, b_start, b_use_imm, b_ba, b_busy, b_done, b_err;
  logic [3:0]  b_op;
  logic [2:0]  b_ra, b_rb, b_rc;
  logic [15:0] b_imm, b_in, b_out, b_bus;
  logic [31:0] b_z;

  bus_datapath_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .imm(imm), .use_imm(use_imm), .ba_mode(ba_mode), .in_port(in_port),
    .out_port(out_port), .busy(busy), .done(done), .err(err), .bus_out(bus_out),
    .z_out(z_out)
  );

  bus_datapath_seq #(.WIDTH(16), .NREGS(8)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .op(b_op), .ra(b_ra), .rb(b_rb),
    .rc(b_rc), .imm(b_imm), .use_imm(b_use_imm), .ba_mode(b_ba), .in_port(b_in),
    .out_port(b_out), .busy(b_busy), .done(b_done), .err(b_err), .bus_out(b_bus),
    .z_out(b_z)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state updated per whole operation.
  logic [31:0] m_regs [16];
  logic [31:0] m_hi, m_lo, m_out;
  logic [63:0] m_z;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_hi = '0; m_lo = '0; m_out = '0; m_z = '0;
  endtask

  function automatic logic [31:0] model_src(input int r, input logic ba);
    return (ba && r == 0) ? 32'd0 : m_regs[r];
  endfunction

  task automatic model_exec(input int o, input int a_ra, input int a_rb, input int a_rc,
                            input logic [31:0] a_imm, input logic a_use, input logic a_ba,
                            input logic [31:0] a_in);
    logic [31:0] a, b, r;
    longint sa, sb;
    a = model_src(a_rb, a_ba);
    b = a_use ? a_imm : model_src(a_rc, a_ba);
    r = '0;
    case (o)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a << b[4:0];
      5: r = a >> b[4:0];
      default: r = '0;
    endcase
    if (o <= 5) begin
      m_z = {32'd0, r};
      m_regs[a_ra] = r;
    end else if (o == 6) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_z = 64'(sa * sb);
      m_hi = m_z[63:32];
      m_lo = m_z[31:0];
    end else if (o == 7) m_regs[a_ra] = a_in;
    else if (o == 8) m_out = a;
    else if (o == 9) m_regs[a_ra] = m_hi;
    else if (o == 10) m_regs[a_ra] = m_lo;
  endtask

  function automatic int exp_lat(input int o);
    if (o <= 6) return 4;
    if (o <= 10) return 2;
    return 1;
  endfunction

  // Issue one op; while busy, scramble inputs and pulse start to prove they are ignored.
  task automatic do_op(input int o, input int a_ra, input int a_rb, input int a_rc,
                       input logic [31:0] a_imm, input logic a_use, input logic a_ba,
                       input logic [31:0] a_in, output int lat, output logic e,
                       output logic [31:0] bus1, output logic [31:0] bus_d);
    @(negedge clk);
    op = 4'(o); ra = 4'(a_ra); rb = 4'(a_rb); rc = 4'(a_rc);
    imm = a_imm; use_imm = a_use; ba_mode = a_ba; in_port = a_in; start = 1'b1;
    @(posedge clk);
    lat = -1; e = 1'b0; bus1 = '0; bus_d = '1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus1 = bus_out;
      if (done) begin
        lat = c; e = err; bus_d = bus_out; start = 1'b0;
        break;
      end
      start = 1'($urandom); op = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
      rc = 4'($urandom); imm = $urandom; use_imm = 1'($urandom); ba_mode = 1'($urandom);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int          o, ra, rb, rc;
    logic [31:0] imm;
    int          use_i, ba;
    logic [31:0] inv;
    int          lat, e, cz;
    logic [63:0] z;
    int          co;
    logic [31:0] ov;
  } vec_t;

  function automatic vec_t mk(int o, int a_ra, int a_rb, int a_rc, logic [31:0] a_imm,
                              int u, int b, logic [31:0] inv, int lat, int e, int cz,
                              logic [63:0] z, int co, logic [31:0] ov);
    vec_t v;
    v.o = o; v.ra = a_ra; v.rb = a_rb; v.rc = a_rc; v.imm = a_imm; v.use_i = u; v.ba = b;
    v.inv = inv; v.lat = lat; v.e = e; v.cz = cz; v.z = z; v.co = co; v.ov = ov;
    return v;
  endfunction

  task automatic run_b(input int o, input int a_ra, input int a_rb, input int a_rc,
                       input logic [15:0] a_in, output int lat);
    @(negedge clk);
    b_op = 4'(o); b_ra = 3'(a_ra); b_rb = 3'(a_rb); b_rc = 3'(a_rc); b_in = a_in;
    b_start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_done) begin lat = c; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int lat;
    logic e;
    logic [31:0] bus1, bus_d, exp_a;
    int o, r_a, r_b, r_c;
    logic [31:0] r_imm, r_in;
    logic r_use, r_ba;

    reset = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; imm = '0;
    use_imm = 1'b0; ba_mode = 1'b0; in_port = '0;
    b_reset = 1'b1; b_start = 1'b0; b_op = '0; b_ra = '0; b_rb = '0; b_rc = '0;
    b_imm = '0; b_use_imm = 1'b0; b_ba = 1'b0; b_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_bus", 64'(bus_out), 64'd0);
    check("rst_z", z_out, 64'd0);
    check("rst_out", 64'(out_port), 64'd0);
    reset = 1'b0; b_reset = 1'b0;
    model_reset();

    tbl.push_back(mk(7, 1, 0, 0, 0, 0, 0, 32'd5, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 2, 0, 0, 0, 0, 0, 32'd7, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 2, 0, 0, 0, 0, 4, 0, 1, 64'd12, 0, 0));
    tbl.push_back(mk(8, 0, 3, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'd12));
    tbl.push_back(mk(7, 1, 0, 0, 0, 0, 0, 32'h7FFF_FFFF, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1, 0, 32'd2, 1, 0, 0, 4, 0, 1, 64'h7FFF_FFFD, 0, 0));
    tbl.push_back(mk(8, 0, 4, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h7FFF_FFFD));
    tbl.push_back(mk(6, 9, 1, 1, 0, 0, 0, 0, 4, 0, 1, 64'h3FFF_FFFF_0000_0001, 0, 0));
    tbl.push_back(mk(10, 5, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8, 0, 5, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'd1));
    tbl.push_back(mk(9, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8, 0, 7, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h3FFF_FFFF));
    tbl.push_back(mk(8, 0, 9, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'd0));
    tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 32'h100, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6, 0, 0, 32'd4, 1, 1, 0, 4, 0, 1, 64'd4, 0, 0));
    tbl.push_back(mk(8, 0, 6, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'd4));
    tbl.push_back(mk(0, 6, 0, 0, 32'd4, 1, 0, 0, 4, 0, 1, 64'h104, 0, 0));
    tbl.push_back(mk(12, 6, 0, 0, 0, 0, 0, 0, 1, 1, 1, 64'h104, 0, 0));
    tbl.push_back(mk(8, 0, 6, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h104));
    tbl.push_back(mk(8, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 32'd0));
    tbl.push_back(mk(8, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h100));
    tbl.push_back(mk(2, 8, 3, 6, 0, 0, 0, 0, 4, 0, 1, 64'd4, 0, 0));
    tbl.push_back(mk(3, 8, 8, 3, 0, 0, 0, 0, 4, 0, 1, 64'hC, 0, 0));
    tbl.push_back(mk(8, 0, 8, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 32'hC));
    tbl.push_back(mk(5, 10, 1, 0, 32'h24, 1, 0, 0, 4, 0, 1, 64'h07FF_FFFF, 0, 0));
    tbl.push_back(mk(4, 13, 2, 0, 32'h21, 1, 0, 0, 4, 0, 1, 64'hE, 0, 0));
    tbl.push_back(mk(1, 11, 2, 3, 0, 0, 0, 0, 4, 0, 1, 64'hFFFF_FFFB, 0, 0));
    tbl.push_back(mk(0, 12, 11, 2, 0, 0, 0, 0, 4, 0, 1, 64'd2, 0, 0));
    tbl.push_back(mk(15, 12, 0, 0, 0, 0, 0, 0, 1, 1, 1, 64'd2, 0, 0));

    foreach (tbl[i]) begin
      do_op(tbl[i].o, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].imm, 1'(tbl[i].use_i),
            1'(tbl[i].ba), tbl[i].inv, lat, e, bus1, bus_d);
      model_exec(tbl[i].o, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].imm, 1'(tbl[i].use_i),
                 1'(tbl[i].ba), tbl[i].inv);
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].e));
      check($sformatf("tbl%0d_bus_done", i), 64'(bus_d), 64'd0);
      if (tbl[i].cz != 0) check($sformatf("tbl%0d_z", i), z_out, tbl[i].z);
      if (tbl[i].co != 0) check($sformatf("tbl%0d_out", i), 64'(out_port), 64'(tbl[i].ov));
    end

    // Reset during T_Z of an ADD, with start held high through the reset cycle.
    @(negedge clk);
    op = 4'd0; ra = 4'd13; rb = 4'd1; rc = 4'd2; use_imm = 1'b0; ba_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_z", z_out, 64'd0);
    check("abort_out", 64'(out_port), 64'd0);
    check("abort_bus", 64'(bus_out), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", 64'(busy), 64'd0);
    model_reset();
    for (int r = 0; r < 16; r++) begin
      do_op(8, 0, r, 0, 0, 1'b0, 1'b0, 0, lat, e, bus1, bus_d);
      model_exec(8, 0, r, 0, 0, 1'b0, 1'b0, 0);
      check($sformatf("abort_r%0d", r), 64'(out_port), 64'd0);
    end

    // Random ops against the reference model.
    for (int n = 0; n < 80; n++) begin
      o = int'($urandom_range(0, 15));
      r_a = int'($urandom_range(0, 15)); r_b = int'($urandom_range(0, 15));
      r_c = int'($urandom_range(0, 15));
      r_imm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom;
      r_use = 1'($urandom); r_ba = 1'($urandom); r_in = $urandom;
      exp_a = model_src(r_b, r_ba);
      do_op(o, r_a, r_b, r_c, r_imm, r_use, r_ba, r_in, lat, e, bus1, bus_d);
      model_exec(o, r_a, r_b, r_c, r_imm, r_use, r_ba, r_in);
      check($sformatf("rnd%0d_op%0d_lat", n, o), 64'(lat), 64'(exp_lat(o)));
      check($sformatf("rnd%0d_err", n), 64'(e), 64'(o > 10));
      check($sformatf("rnd%0d_z", n), z_out, m_z);
      check($sformatf("rnd%0d_out", n), 64'(out_port), 64'(m_out));
      check($sformatf("rnd%0d_bus_done", n), 64'(bus_d), 64'd0);
      if (o <= 6) check($sformatf("rnd%0d_bus_ty", n), 64'(bus1), 64'(exp_a));
    end
    for (int r = 0; r < 16; r++) begin
      do_op(8, 0, r, 0, 0, 1'b0, 1'b0, 0, lat, e, bus1, bus_d);
      model_exec(8, 0, r, 0, 0, 1'b0, 1'b0, 0);
      check($sformatf("final_r%0d", r), 64'(out_port), 64'(m_regs[r]));
    end

    // 16-bit instance: shift amount uses only the low 4 bits of the operand.
    run_b(7, 1, 0, 0, 16'h0001, lat);
    run_b(7, 2, 0, 0, 16'h0013, lat);
    run_b(4, 3, 1, 2, 16'h0000, lat);
    check("b_shl_lat", 64'(lat), 64'd4);
    check("b_shl_z", 64'(b_z), 64'h0000_0008);
    check("b_shl_err", 64'(b_err), 64'd0);
    run_b(8, 0, 3, 0, 16'h0000, lat);
    check("b_out_lat", 64'(lat), 64'd2);
    check("b_out", 64'(b_out), 64'h0008);
    check("b_bus_done", 64'(b_bus), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
